// File: rtl/div_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
// The slave side is the divider; the master side is the EX-stage controller.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  cancel;
    logic                  busy;
    logic                  stall_req;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport slave (
        input  start, signed_div, dividend, divisor, cancel,
        output busy, stall_req, done, quotient, remainder
    );

    modport master (
        output start, signed_div, dividend, divisor, cancel,
        input  busy, stall_req, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider, one quotient bit per cycle, serving DIV/DIVU.
// Quotient goes to LO, remainder to HI; stalls the pipe while an operation is in flight.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prem_q, prem_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;

    logic                  accept;
    logic                  commit;
    logic [DATA_WIDTH-1:0] dvd_abs, dsr_abs;
    logic [DATA_WIDTH:0]   shl;
    logic [DATA_WIDTH-1:0] res_quo, res_rem;

    assign accept  = (state_q == S_IDLE) && bus.start && !bus.cancel;
    assign commit  = (state_q == S_DONE) && !bus.cancel;

    assign dvd_abs = (bus.signed_div && bus.dividend[MSB]) ? -bus.dividend : bus.dividend;
    assign dsr_abs = (bus.signed_div && bus.divisor[MSB])  ? -bus.divisor  : bus.divisor;

    // dvd_q doubles as the quotient accumulator: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign shl     = {prem_q, dvd_q[MSB]};
    assign res_quo = q_neg_q ? -dvd_q  : dvd_q;
    assign res_rem = r_neg_q ? -prem_q : prem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = CNT_WIDTH'(DATA_WIDTH);
                    if (bus.divisor == '0) begin
                        // Fixed divide-by-zero result routed through the normal
                        // result path: all-ones quotient, raw dividend remainder.
                        dvd_d   = '1;
                        prem_d  = bus.dividend;
                        dsr_d   = '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = dvd_abs;
                        dsr_d   = dsr_abs;
                        prem_d  = '0;
                        q_neg_d = bus.signed_div & (bus.dividend[MSB] ^ bus.divisor[MSB]);
                        r_neg_d = bus.signed_div & bus.dividend[MSB];
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (shl >= {1'b0, dsr_q}) begin
                        // True difference is below dsr_q, so the low bits are exact.
                        prem_d = shl[MSB:0] - dsr_q;
                        dvd_d  = {dvd_q[MSB-1:0], 1'b1};
                    end else begin
                        prem_d = shl[MSB:0];
                        dvd_d  = {dvd_q[MSB-1:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_d == '0)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    quo_d = res_quo;
                    rem_d = res_rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    // Results are visible during the done cycle itself, then held in quo_q/rem_q.
    assign bus.busy      = (state_q == S_DIV);
    assign bus.done      = commit;
    assign bus.stall_req = (state_q == S_DIV) || accept;
    assign bus.quotient  = commit ? res_quo : quo_q;
    assign bus.remainder = commit ? res_rem : rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// cancel, async reset and ignored starts.
module tb_div_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_unit_if #(.DATA_WIDTH(32)) dif();

    div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.start      = 1'b1;
        dif.signed_div = sgn;
        dif.dividend   = a;
        dif.divisor    = b;
        #1;
    endtask

    // Bounded wait for done; lat=100 signals a timeout.
    task automatic wait_done(output int lat, output int bcnt, output int scnt, output int both);
        lat = 0; bcnt = 0; scnt = 0; both = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dif.start = 1'b0;
            #1;
            lat++;
            if (dif.busy) bcnt++;
            if (dif.stall_req) scnt++;
            if (dif.busy && dif.done) both++;
            if (dif.done) break;
        end
    endtask

    task automatic test_reset();
        dif.start = 1'b0; dif.signed_div = 1'b0; dif.dividend = '0;
        dif.divisor = '0; dif.cancel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.stall_req} !== 3'b000 || dif.quotient !== 32'h0 || dif.remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b q=%h r=%h, expected all zero",
                     dif.busy, dif.done, dif.stall_req, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat, bcnt, scnt, both;
        issue(1'b0, 32'd100, 32'd7);
        checks++;
        if (dif.stall_req !== 1'b1 || dif.busy !== 1'b0) begin
            errors++;
            $display("FAIL divu_start_cycle: stall=%b busy=%b, expected stall=1 busy=0", dif.stall_req, dif.busy);
        end
        wait_done(lat, bcnt, scnt, both);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        checks++;
        if (bcnt !== 32 || scnt !== 32 || both !== 0) begin
            errors++;
            $display("FAIL divu_busy_stall: busy=%0d stall=%0d overlap=%0d, expected 32 32 0", bcnt, scnt, both);
        end
        checks++;
        if (dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
            errors++;
            $display("FAIL divu_100_7: got q=%h r=%h expected q=0000000e r=00000002", dif.quotient, dif.remainder);
        end
        @(negedge clk); #1;
        checks++;
        if (dif.done !== 1'b0 || dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
            errors++;
            $display("FAIL divu_hold: done=%b q=%h r=%h expected done=0 q=0000000e r=00000002",
                     dif.done, dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [3] = '{32'hFFFFFF9C, 32'd100,     32'hFFFFFF9C};
        logic [31:0] tb [3] = '{32'd7,       32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] tq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
        logic [31:0] tr [3] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE};
        int lat, bcnt, scnt, both;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ta[i], tb[i]);
            wait_done(lat, bcnt, scnt, both);
            checks++;
            if (lat !== 33 || dif.quotient !== tq[i] || dif.remainder !== tr[i]) begin
                errors++;
                $display("FAIL div_signed_%0d: lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                         i, lat, dif.quotient, dif.remainder, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic        ts [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ta [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        logic [31:0] tb [4] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd7};
        logic [31:0] tq [4] = '{32'h80000000, 32'hFFFFFFFF, 32'd1,        32'd0};
        logic [31:0] tr [4] = '{32'd0,        32'd0,        32'd0,        32'd5};
        int lat, bcnt, scnt, both;
        for (int i = 0; i < 4; i++) begin
            issue(ts[i], ta[i], tb[i]);
            wait_done(lat, bcnt, scnt, both);
            checks++;
            if (lat !== 33 || dif.quotient !== tq[i] || dif.remainder !== tr[i]) begin
                errors++;
                $display("FAIL boundary_%0d: lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                         i, lat, dif.quotient, dif.remainder, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic        ts [2] = '{1'b0, 1'b1};
        logic [31:0] ta [2] = '{32'h12345678, 32'hFFFFFF9C};
        int lat, bcnt, scnt, both;
        for (int i = 0; i < 2; i++) begin
            issue(ts[i], ta[i], 32'd0);
            checks++;
            if (dif.stall_req !== 1'b1) begin
                errors++;
                $display("FAIL dz_stall_%0d: stall=%b expected 1", i, dif.stall_req);
            end
            wait_done(lat, bcnt, scnt, both);
            checks++;
            if (lat !== 1 || bcnt !== 0 || dif.quotient !== 32'hFFFFFFFF || dif.remainder !== ta[i]) begin
                errors++;
                $display("FAIL dz_%0d: lat=%0d busy=%0d q=%h r=%h expected lat=1 busy=0 q=ffffffff r=%h",
                         i, lat, bcnt, dif.quotient, dif.remainder, ta[i]);
            end
        end
    endtask

    task automatic test_cancel();
        int lat, bcnt, scnt, both, ndone;
        issue(1'b0, 32'd100, 32'd7);
        wait_done(lat, bcnt, scnt, both);
        issue(1'b0, 32'd50, 32'd5);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
            if (c == 10) dif.cancel = 1'b1;
        end
        #1;
        checks++;
        if (dif.busy !== 1'b1 || dif.done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_in_div: busy=%b done=%b expected busy=1 done=0", dif.busy, dif.done);
        end
        @(negedge clk);
        dif.cancel = 1'b0;
        #1;
        checks++;
        if (dif.busy !== 1'b0 || dif.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle: busy=%b stall=%b expected 0 0", dif.busy, dif.stall_req);
        end
        ndone = 0;
        repeat (40) begin @(negedge clk); #1; if (dif.done) ndone++; end
        checks++;
        if (ndone !== 0 || dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
            errors++;
            $display("FAIL cancel_no_done: dones=%0d q=%h r=%h expected 0 q=0000000e r=00000002",
                     ndone, dif.quotient, dif.remainder);
        end
        issue(1'b0, 32'd9, 32'd2);
        wait_done(lat, bcnt, scnt, both);
        checks++;
        if (lat !== 33 || dif.quotient !== 32'd4 || dif.remainder !== 32'd1) begin
            errors++;
            $display("FAIL after_cancel_9_2: lat=%0d q=%h r=%h expected lat=33 q=4 r=1",
                     lat, dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_ignored_start();
        int ndone, dlat;
        logic [31:0] dq, dr;
        ndone = 0; dlat = 0; dq = '0; dr = '0;
        issue(1'b0, 32'd20, 32'd3);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) dif.start = 1'b0;
            if (c == 5) begin dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd10; end
            if (c == 6) dif.start = 1'b0;
            #1;
            if (dif.done) begin ndone++; dlat = c; dq = dif.quotient; dr = dif.remainder; end
        end
        checks++;
        if (ndone !== 1 || dlat !== 33 || dq !== 32'd6 || dr !== 32'd2) begin
            errors++;
            $display("FAIL start_in_div: dones=%0d lat=%0d q=%h r=%h expected 1 33 q=6 r=2", ndone, dlat, dq, dr);
        end
        @(negedge clk);
        dif.start = 1'b1; dif.cancel = 1'b1; dif.dividend = 32'd77; dif.divisor = 32'd7;
        #1;
        checks++;
        if (dif.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL start_with_cancel_stall: stall=%b expected 0", dif.stall_req);
        end
        @(negedge clk);
        dif.start = 1'b0; dif.cancel = 1'b0;
        ndone = 0;
        repeat (40) begin @(negedge clk); #1; if (dif.done || dif.busy) ndone++; end
        checks++;
        if (ndone !== 0 || dif.quotient !== 32'd6) begin
            errors++;
            $display("FAIL start_with_cancel: active_cycles=%0d q=%h expected 0 q=6", ndone, dif.quotient);
        end
    endtask

    task automatic test_async_reset();
        int ndone, lat, bcnt, scnt, both;
        issue(1'b0, 32'd1000, 32'd10);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.stall_req} !== 3'b000 || dif.quotient !== 32'h0 || dif.remainder !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b stall=%b q=%h r=%h expected all zero",
                     dif.busy, dif.done, dif.stall_req, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin @(negedge clk); #1; if (dif.done) ndone++; end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL reset_no_done: dones=%0d expected 0", ndone); end
        issue(1'b0, 32'd1000, 32'd10);
        wait_done(lat, bcnt, scnt, both);
        checks++;
        if (lat !== 33 || dif.quotient !== 32'd100 || dif.remainder !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_1000_10: lat=%0d q=%h r=%h expected lat=33 q=64 r=0",
                     lat, dif.quotient, dif.remainder);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundary();
        test_div_by_zero();
        test_cancel();
        test_ignored_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
